// File: rtl/mips_ctrl_pkg.sv
// Shared encodings and the per-stage control bundle for the MIPS pipeline control unit.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned JUMP_W  = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FUNCT_W-1:0] FUNCT_JR  = 6'b001000;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_t;

    typedef struct packed {
        logic      regwrite;
        logic      memtoreg;
        logic      memwrite;
        logic      alusrc;
        logic      regdst;
        logic      jal;
        logic      branch;
        logic      nbranch;
        alu_ctrl_t alucontrol;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        regwrite:   1'b0,
        memtoreg:   1'b0,
        memwrite:   1'b0,
        alusrc:     1'b0,
        regdst:     1'b0,
        jal:        1'b0,
        branch:     1'b0,
        nbranch:    1'b0,
        alucontrol: ALU_ADD
    };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational main/ALU decoder: op/funct to control bundle, jump select, immext and illegal flag.
module ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter bit EXT_ISA = 1'b1
) (
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output ctrl_t              ctrl,
    output logic [JUMP_W-1:0]  jump,
    output logic               immext,
    output logic               illegal
);

    // Unknown encodings fall through to the bubble so no X ever leaves the decoder.
    always_comb begin
        ctrl    = CTRL_BUBBLE;
        jump    = '0;
        immext  = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_JR:  jump = 3'b010;
                    FUNCT_ADD: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alucontrol = ALU_ADD; end
                    FUNCT_SUB: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alucontrol = ALU_SUB; end
                    FUNCT_AND: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alucontrol = ALU_AND; end
                    FUNCT_OR:  begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alucontrol = ALU_OR;  end
                    FUNCT_SLT: begin ctrl.regwrite = 1'b1; ctrl.regdst = 1'b1; ctrl.alucontrol = ALU_SLT; end
                    default:   illegal = 1'b1;
                endcase
            end
            OP_J: jump = 3'b001;
            OP_JAL: begin
                jump          = 3'b101;
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.jal      = 1'b1;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            OP_SW: begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch     = 1'b1;
                ctrl.alucontrol = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
            end
            OP_BNE: begin
                if (EXT_ISA) begin
                    ctrl.nbranch    = 1'b1;
                    ctrl.alucontrol = ALU_SUB;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ANDI: begin
                if (EXT_ISA) begin
                    ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alucontrol = ALU_AND; immext = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_ORI: begin
                if (EXT_ISA) begin
                    ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alucontrol = ALU_OR; immext = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_SLTI: begin
                if (EXT_ISA) begin
                    ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alucontrol = ALU_SLT;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes in D, carries the control bundle through E/M/W, resolves branches.
module pipe_ctrl_unit
    import mips_ctrl_pkg::*;
#(
    parameter bit BRANCH_IN_DECODE = 1'b0,
    parameter bit EXT_ISA          = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OP_W-1:0]     op_d,
    input  logic [FUNCT_W-1:0]  funct_d,
    input  logic                equal_d,
    input  logic                zero_e,
    input  logic                stall_e,
    input  logic                flush_e,
    output logic [JUMP_W-1:0]   jump_d,
    output logic                immext_d,
    output logic                illegal_d,
    output logic                pcsrc,
    output logic                regwrite_e,
    output logic                memtoreg_e,
    output logic                memwrite_e,
    output logic                alusrc_e,
    output logic                regdst_e,
    output logic                jal_e,
    output logic [2:0]          alucontrol_e,
    output logic                regwrite_m,
    output logic                memtoreg_m,
    output logic                memwrite_m,
    output logic                jal_m,
    output logic                regwrite_w,
    output logic                memtoreg_w,
    output logic                jal_w,
    output logic                illegal_seen
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_e;
    logic  unused_c;

    ctrl_decode #(
        .EXT_ISA (EXT_ISA)
    ) u_decode (
        .op      (op_d),
        .funct   (funct_d),
        .ctrl    (ctrl_d),
        .jump    (jump_d),
        .immext  (immext_d),
        .illegal (illegal_d)
    );

    // E register: flush wins over stall, stall holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_e <= CTRL_BUBBLE;
        end else if (flush_e) begin
            ctrl_e <= CTRL_BUBBLE;
        end else if (!stall_e) begin
            ctrl_e <= ctrl_d;
        end
    end

    // Sticky flag: only an illegal decode actually captured into E counts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_seen <= 1'b0;
        end else if (!flush_e && !stall_e && illegal_d) begin
            illegal_seen <= 1'b1;
        end
    end

    // M register: a held E must not also advance, so M takes a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regwrite_m <= 1'b0;
            memtoreg_m <= 1'b0;
            memwrite_m <= 1'b0;
            jal_m      <= 1'b0;
        end else if (stall_e && !flush_e) begin
            regwrite_m <= 1'b0;
            memtoreg_m <= 1'b0;
            memwrite_m <= 1'b0;
            jal_m      <= 1'b0;
        end else begin
            regwrite_m <= ctrl_e.regwrite;
            memtoreg_m <= ctrl_e.memtoreg;
            memwrite_m <= ctrl_e.memwrite;
            jal_m      <= ctrl_e.jal;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regwrite_w <= 1'b0;
            memtoreg_w <= 1'b0;
            jal_w      <= 1'b0;
        end else begin
            regwrite_w <= regwrite_m;
            memtoreg_w <= memtoreg_m;
            jal_w      <= jal_m;
        end
    end

    assign regwrite_e   = ctrl_e.regwrite;
    assign memtoreg_e   = ctrl_e.memtoreg;
    assign memwrite_e   = ctrl_e.memwrite;
    assign alusrc_e     = ctrl_e.alusrc;
    assign regdst_e     = ctrl_e.regdst;
    assign jal_e        = ctrl_e.jal;
    assign alucontrol_e = 3'(ctrl_e.alucontrol);

    always_comb begin
        pcsrc = 1'b0;
        if (BRANCH_IN_DECODE) begin
            pcsrc = (ctrl_d.branch & equal_d) | (ctrl_d.nbranch & ~equal_d);
        end else begin
            pcsrc = (ctrl_e.branch & zero_e) | (ctrl_e.nbranch & ~zero_e);
        end
    end

    // Only one of the two compare sources is consumed, depending on BRANCH_IN_DECODE.
    assign unused_c = &{1'b0, equal_d, zero_e, ctrl_e.branch, ctrl_e.nbranch};

endmodule
